nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that performs a wide (4*NIBBLES-bit) addition by time-sharing one
//  external combinational 4-bit adder slice, one nibble per clock, LSB first.
//  Holds the operands, steps the slice through the nibbles, and chains the
//  carry in a register between nibbles. Assembles sum/cout; start/busy/done handshake.
//  Sits between the requesting logic and the shared 4-bit adder datapath.
// PARAMETERS
//  NIBBLES   4   number of 4-bit digits per operand (>=2); operand width W=4*NIBBLES
// PORTS
//  clk       in   1    single clock; all state updates on rising edge
//  rst       in   1    synchronous, active-high reset
//  start     in   1    request; sampled only in IDLE or DONE
//  a         in   W    operand A, captured on accepted start
//  b         in   W    operand B, captured on accepted start
//  cin       in   1    carry-in to nibble 0, captured on accepted start
//  busy      out  1    high in RUN
//  done      out  1    one-cycle pulse in DONE; sum/cout valid from this cycle
//  sum       out  W    result register, held until next accepted start
//  cout      out  1    carry out of top nibble, held with sum
//  add_x     out  4    nibble of A to adder slice
//  add_y     out  4    nibble of B to adder slice
//  add_cin   out  1    carry to adder slice (= carry register)
//  add_s     in   4    slice sum (combinational from add_x/add_y/add_cin)
//  add_cout  in   1    slice carry out
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, carry=0, opA/opB=0, sum=0, cout=0, busy=0, done=0.
//  - add_x=opA[4*idx+:4], add_y=opB[4*idx+:4], add_cin=carry; driven every cycle.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: start=1 -> latch a,b; carry<=cin; idx<=0; sum<=0; cout<=0; ->RUN.
//    RUN : sum[4*idx+:4]<=add_s; carry<=add_cout; idx<=idx+1;
//          if idx==NIBBLES-1: cout<=add_cout, idx<=0, ->DONE.
//    DONE: done=1 for exactly this cycle. start=1 -> accepted as in IDLE, ->RUN
//          (back-to-back, no idle gap); else ->IDLE.
//  - Latency: start accepted at edge 0 -> done high during cycle NIBBLES+1 after it
//    (NIBBLES RUN cycles + 1 DONE cycle). Throughput 1 op / (NIBBLES+1) cycles.
//  - start while busy: ignored, no effect on operands or progress.
//  - a/b/cin changes after acceptance: no effect (operands registered).
//  - idx width = clog2(NIBBLES); never exceeds NIBBLES-1.
//  - rst mid-RUN: abort, all regs to reset values next edge, no done pulse.
//  - rst and start same cycle: rst wins.
//  - sum nibbles are written in place; partial sum visible during RUN, final
//    only from DONE onward.
// CONFIGURATION
//  OVERFLOW_DETECT_EN defined: extra port ovf (out, 1): signed two's-complement
//   overflow, ovf<=(opA[W-1]==opB[W-1]) && (add_s[3]!=opA[W-1]) on the final RUN
//   cycle; reset 0; cleared on accepted start; held with sum.
//  Not defined: no ovf port, no overflow logic; all other behaviour identical.
// TESTING (NIBBLES=4 unless noted)
//  1. a=0x0001,b=0x0004,cin=0, start 1 cycle -> busy 4 cycles, done pulse, sum=0x0005, cout=0.
//  2. a=0xFFFF,b=0x0001,cin=0 -> sum=0x0000, cout=1 (carry ripples all nibbles); with
//     cin=1, a=0x0000,b=0x0000 -> sum=0x0001, cout=0.
//  3. OVERFLOW_DETECT_EN: a=0x7FFF,b=0x0001 -> sum=0x8000, ovf=1, cout=0;
//     a=0x8000,b=0x8000 -> sum=0x0000, ovf=1, cout=1.
//  4. start pulses with new operands during RUN -> ignored; result equals first op.
//  5. rst asserted in 2nd RUN cycle -> next cycle all outputs 0, state IDLE, no done.
//  6. start held high through DONE with a=0x1234,b=0x1111 -> next op begins with no
//     IDLE cycle; second done 5 cycles after first; sum=0x2345.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request-side interface of nibble_serial_add_ctrl.
// The requester drives start/a/b/cin. The sequencer returns busy/done/sum/cout.
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Performs a 4*NIBBLES-bit addition through one shared external 4-bit adder
// slice. It processes one nibble per clock, starting with the LSB, and keeps
// the carry between nibbles in a register.
// Optional feature: define OVERFLOW_DETECT_EN to add the ovf_o port, which
// reports signed two's-complement overflow of the result.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    nibble_serial_add_ctrl_if.slave   req,
    output logic [3:0]                add_x_o,
    output logic [3:0]                add_y_o,
    output logic                      add_cin_o,
    input  logic [3:0]                add_s_i,
    input  logic                      add_cout_i
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic                      ovf_o
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  opa_q,   opa_d;
    logic [W-1:0]  opb_q,   opb_d;
    logic [W-1:0]  sum_q,   sum_d;
    logic          cout_q,  cout_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          accept_s;
`ifdef OVERFLOW_DETECT_EN
    logic          ovf_q,   ovf_d;
`endif

    // Bit offset of the current nibble (idx*4).
    logic [IW+1:0] nib_base_s;
    assign nib_base_s = {idx_q, 2'b00};

    // The slice always sees the current nibble of the held operands.
    assign add_x_o   = opa_q[nib_base_s +: 4];
    assign add_y_o   = opb_q[nib_base_s +: 4];
    assign add_cin_o = carry_q;

    assign req.busy = busy_q;
    assign req.done = done_q;
    assign req.sum  = sum_q;
    assign req.cout = cout_q;
`ifdef OVERFLOW_DETECT_EN
    assign ovf_o    = ovf_q;
`endif

    // Next-state, datapath and status computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef OVERFLOW_DETECT_EN
        ovf_d   = ovf_q;
`endif
        // A new request is accepted only when no operation is in flight.
        accept_s = req.start && ((state_q == S_IDLE) || (state_q == S_DONE));

        if (accept_s) begin
            opa_d   = req.a;
            opb_d   = req.b;
            carry_d = req.cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_d   = 1'b0;
`endif
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_RUN: begin
                    // Write the result nibble in place and chain the carry.
                    sum_d[nib_base_s +: 4] = add_s_i;
                    carry_d = add_cout_i;
                    if (idx_q == LAST_IDX) begin
                        cout_d  = add_cout_i;
                        idx_d   = '0;
`ifdef OVERFLOW_DETECT_EN
                        ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (add_s_i[3] != opa_q[W-1]);
`endif
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef OVERFLOW_DETECT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl.
// A behavioural 4-bit slice closes the adder loop. Expected results are
// queued when a start is driven and compared when done pulses.
module tb_nibble_serial_add_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) req_if ();

    logic [3:0] add_x, add_y, add_s;
    logic       add_cin, add_cout;
    assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0000, add_cin};

`ifdef OVERFLOW_DETECT_EN
    logic ovf;
`endif

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req        (req_if),
        .add_x_o    (add_x),
        .add_y_o    (add_y),
        .add_cin_o  (add_cin),
        .add_s_i    (add_s),
        .add_cout_i (add_cout)
`ifdef OVERFLOW_DETECT_EN
        ,
        .ovf_o      (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks_cnt = 0;
    int   errors_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t         e;
        logic [W:0]   t;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    // Compare every done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && req_if.done) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("sum", 64'(req_if.sum), 64'(mon_e.sum));
                check_val("cout", 64'(req_if.cout), 64'(mon_e.cout));
`ifdef OVERFLOW_DETECT_EN
                check_val("ovf", 64'(ovf), 64'(mon_e.ovf));
`endif
            end
        end
    end

    task automatic push_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        req_if.start = 1'b1;
        req_if.a     = a;
        req_if.b     = b;
        req_if.cin   = cin;
        exp_q.push_back(model(a, b, cin));
    endtask

    // One full operation. The operands are scrambled after acceptance.
    // With noise set, ignored start pulses are also driven while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit noise);
        int n, busy_n;
        bit got;
        @(negedge clk);
        push_start(a, b, cin);
        @(posedge clk);
        #1;
        req_if.start = 1'b0;
        req_if.a     = W'($urandom);
        req_if.b     = W'($urandom);
        req_if.cin   = 1'($urandom_range(0, 1));
        n = 0; busy_n = 0; got = 1'b0;
        while (!got && n < NIBBLES + 4) begin
            @(negedge clk);
            n++;
            if (req_if.busy) busy_n++;
            if (req_if.done) begin
                got = 1'b1;
            end else if (noise && n < NIBBLES) begin
                req_if.start = 1'($urandom_range(0, 1));
                req_if.a     = W'($urandom);
                req_if.b     = W'($urandom);
            end else begin
                req_if.start = 1'b0;
            end
        end
        req_if.start = 1'b0;
        check_val("latency", 64'(n), 64'(NIBBLES + 1));
        check_val("busy_cycles", 64'(busy_n), 64'(NIBBLES));
    endtask

    initial begin
        int  m;
        bit  got;
        req_if.start = 1'b0;
        req_if.a     = '0;
        req_if.b     = '0;
        req_if.cin   = 1'b0;

        // Reset state, and a start raised while reset is high must be ignored.
        repeat (2) @(negedge clk);
        req_if.start = 1'b1;
        req_if.a     = 16'h1234;
        req_if.b     = 16'h4321;
        @(negedge clk);
        check_val("rst_busy", 64'(req_if.busy), 64'd0);
        check_val("rst_done", 64'(req_if.done), 64'd0);
        check_val("rst_sum", 64'(req_if.sum), 64'd0);
        check_val("rst_cout", 64'(req_if.cout), 64'd0);
        check_val("rst_add_x", 64'(add_x), 64'd0);
        check_val("rst_add_y", 64'(add_y), 64'd0);
        check_val("rst_add_cin", 64'(add_cin), 64'd0);
        req_if.start = 1'b0;
        rst = 1'b0;

        // Simple sum, followed by a check that the result is held.
        run_op(16'h0001, 16'h0004, 1'b0, 1'b0);
        @(negedge clk);
        check_val("held_sum", 64'(req_if.sum), 64'h0005);
        check_val("idle_busy", 64'(req_if.busy), 64'd0);
        check_val("idle_done", 64'(req_if.done), 64'd0);

        // Carry ripples through all nibbles, and carry-in only.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);

        // Signed overflow cases.
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

        // Start pulses during RUN must be ignored.
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        req_if.start = 1'b1;
        req_if.a     = 16'h1111;
        req_if.b     = 16'h2222;
        req_if.cin   = 1'b0;
        @(posedge clk);
        #1;
        req_if.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("partial_sum", 64'(req_if.sum), 64'h0003);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_busy", 64'(req_if.busy), 64'd0);
        check_val("abort_done", 64'(req_if.done), 64'd0);
        check_val("abort_sum", 64'(req_if.sum), 64'd0);
        check_val("abort_cout", 64'(req_if.cout), 64'd0);
        check_val("abort_add_x", 64'(add_x), 64'd0);
        check_val("abort_add_y", 64'(add_y), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_val("abort_no_busy", 64'(req_if.busy), 64'd0);

        // Back-to-back operation: start held through DONE.
        @(negedge clk);
        push_start(16'h00FF, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        req_if.start = 1'b0;
        m = 0; got = 1'b0;
        while (!got && m < NIBBLES + 4) begin
            @(negedge clk);
            m++;
            if (req_if.done) got = 1'b1;
        end
        check_val("b2b_first_done", 64'(got), 64'd1);
        push_start(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        req_if.start = 1'b0;
        m = 0; got = 1'b0;
        while (!got && m < NIBBLES + 4) begin
            @(negedge clk);
            m++;
            if (m == 1) check_val("b2b_no_idle", 64'(req_if.busy), 64'd1);
            if (req_if.done) got = 1'b1;
        end
        check_val("b2b_spacing", 64'(m), 64'(NIBBLES + 1));

        // Random operations.
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'(i % 2));
        end

        repeat (3) @(negedge clk);
        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
